// File: rtl/ice_risc_pkg.sv
// Shared definitions for the ice_risc memory subsystem: bus widths, port
// indices and the arbiter state encoding.
package ice_risc_pkg;

   localparam int cDataWidth = 32;
   localparam int cStrbWidth = 4;

   localparam logic cPortCore   = 1'b0;
   localparam logic cPortLoader = 1'b1;

   typedef enum logic [1:0] {
      stIdle,
      stIssue,
      stWait,
      stAck
   } tArbState;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin picker: on a tie the port not granted last wins.
module mem_arbiter_rr
   import ice_risc_pkg::*;
(
   input  logic iwReq0,
   input  logic iwReq1,
   input  logic iwLastGrant,
   output logic owGrantValid,
   output logic owGrantIdx
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      owGrantValid = iwReq0 | iwReq1;
      owGrantIdx   = cPortCore;
      if (iwReq0 && iwReq1)
         owGrantIdx = ~iwLastGrant;
      else if (iwReq1)
         owGrantIdx = cPortLoader;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the core
// (port 0) and the loader/debug master (port 1); one transaction at a time.
module mem_arbiter
   import ice_risc_pkg::*;
#(
   parameter int pReadLatency = 1
) (
   input  logic                  iwClk,
   input  logic                  iwRst,
   input  logic                  iwReq0,
   input  logic                  iwWe0,
   input  logic [cDataWidth-1:0] iwAddr0,
   input  logic [cDataWidth-1:0] iwWdata0,
   input  logic [cStrbWidth-1:0] iwWstrb0,
   output logic                  owAck0,
   output logic [cDataWidth-1:0] owRdata0,
   input  logic                  iwReq1,
   input  logic                  iwWe1,
   input  logic [cDataWidth-1:0] iwAddr1,
   input  logic [cDataWidth-1:0] iwWdata1,
   input  logic [cStrbWidth-1:0] iwWstrb1,
   output logic                  owAck1,
   output logic [cDataWidth-1:0] owRdata1,
   output logic [cDataWidth-1:0] owMemReadAddr,
   output logic [cDataWidth-1:0] owMemWriteAddr,
   output logic [cDataWidth-1:0] owMemWriteData,
   output logic [cStrbWidth-1:0] owMemWstrb,
   input  logic [cDataWidth-1:0] iwMemReadData
);

   tArbState              state;
   logic [3:0]            waitCnt;
   logic                  grantPort;
   logic                  lastGrant;
   logic                  grantValid;
   logic                  grantIdx;
   logic                  selWe;
   logic [cDataWidth-1:0] selAddr;
   logic [cDataWidth-1:0] selWdata;
   logic [cStrbWidth-1:0] selWstrb;

   mem_arbiter_rr uRr (
      .iwReq0      (iwReq0),
      .iwReq1      (iwReq1),
      .iwLastGrant (lastGrant),
      .owGrantValid(grantValid),
      .owGrantIdx  (grantIdx)
   );

   always_comb begin
      selWe    = (grantIdx == cPortLoader) ? iwWe1    : iwWe0;
      selAddr  = (grantIdx == cPortLoader) ? iwAddr1  : iwAddr0;
      selWdata = (grantIdx == cPortLoader) ? iwWdata1 : iwWdata0;
      selWstrb = (grantIdx == cPortLoader) ? iwWstrb1 : iwWstrb0;
   end

   // The memory-side outputs double as the latched request, so they are loaded
   // at grant and are already valid throughout the ISSUE cycle.
   always_ff @(posedge iwClk) begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      if (iwRst) begin
         state          <= stIdle;
         waitCnt        <= '0;
         grantPort      <= cPortCore;
         lastGrant      <= cPortLoader;
         owAck0         <= 1'b0;
         owAck1         <= 1'b0;
         owRdata0       <= '0;
         owRdata1       <= '0;
         owMemReadAddr  <= '0;
         owMemWriteAddr <= '0;
         owMemWriteData <= '0;
         owMemWstrb     <= '0;
      end else begin
         owAck0 <= 1'b0;
         owAck1 <= 1'b0;
         case (state)
            stIdle: begin
               if (grantValid) begin
                  grantPort      <= grantIdx;
                  owMemReadAddr  <= selAddr;
                  owMemWriteAddr <= selAddr;
                  owMemWriteData <= selWdata;
                  owMemWstrb     <= selWe ? selWstrb : '0;
                  state          <= stIssue;
               end
            end
            stIssue: begin
               owMemWstrb <= '0;
               waitCnt    <= 4'(pReadLatency - 1);
               state      <= stWait;
            end
            stWait: begin
               if (waitCnt == 4'd0) begin
                  if (grantPort == cPortLoader) begin
                     owRdata1 <= iwMemReadData;
                     owAck1   <= 1'b1;
                  end else begin
                     owRdata0 <= iwMemReadData;
                     owAck0   <= 1'b1;
                  end
                  state <= stAck;
               end else begin
                  waitCnt <= waitCnt - 4'd1;
               end
            end
            stAck: begin
               lastGrant <= grantPort;
               state     <= stIdle;
            end
            default: state <= stIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-1 instance on a behavioural memory
// and a latency-3 instance fed with cycle-tagged read data.
module tb_mem_arbiter;
   import ice_risc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
   logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
   logic [3:0]  wstrb0 = 0, wstrb1 = 0;
   logic        ack0, ack1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] memRdAddr, memWrAddr, memWrData, memRdData;
   logic [3:0]  memWstrb;

   logic        req3 = 0;
   logic [31:0] addr3 = 0, memData3 = 0;
   logic        ack3a, ack3b;
   logic [31:0] rdata3a, rdata3b, rd3Addr, wr3Addr, wr3Data;
   logic [3:0]  wstrb3;

   logic [31:0] mem [0:63];
   int checkCount = 0;
   int failCount  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.pReadLatency(1)) dut (
      .iwClk(clk), .iwRst(rst),
      .iwReq0(req0), .iwWe0(we0), .iwAddr0(addr0), .iwWdata0(wdata0), .iwWstrb0(wstrb0),
      .owAck0(ack0), .owRdata0(rdata0),
      .iwReq1(req1), .iwWe1(we1), .iwAddr1(addr1), .iwWdata1(wdata1), .iwWstrb1(wstrb1),
      .owAck1(ack1), .owRdata1(rdata1),
      .owMemReadAddr(memRdAddr), .owMemWriteAddr(memWrAddr), .owMemWriteData(memWrData),
      .owMemWstrb(memWstrb), .iwMemReadData(memRdData)
   );

   mem_arbiter #(.pReadLatency(3)) dut3 (
      .iwClk(clk), .iwRst(rst),
      .iwReq0(req3), .iwWe0(1'b0), .iwAddr0(addr3), .iwWdata0(32'h0), .iwWstrb0(4'h0),
      .owAck0(ack3a), .owRdata0(rdata3a),
      .iwReq1(1'b0), .iwWe1(1'b0), .iwAddr1(32'h0), .iwWdata1(32'h0), .iwWstrb1(4'h0),
      .owAck1(ack3b), .owRdata1(rdata3b),
      .owMemReadAddr(rd3Addr), .owMemWriteAddr(wr3Addr), .owMemWriteData(wr3Data),
      .owMemWstrb(wstrb3), .iwMemReadData(memData3)
   );

   // Latency-1 synchronous memory with byte strobes.
   always @(posedge clk) begin
      memRdData <= mem[memRdAddr[7:2]];
      for (int b = 0; b < 4; b++)
         if (memWstrb[b]) mem[memWrAddr[7:2]][8*b +: 8] <= memWrData[8*b +: 8];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Runs one transaction on the latency-1 instance; n counts cycles after T.
   task automatic runTxn(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input int dropAt,
                         output int ackAt, output int strbCycles, output int strbAt,
                         output int otherAcks, output logic [31:0] rdata,
                         output logic [31:0] seenWaddr, output logic [31:0] seenWdata,
                         output logic [31:0] issueRaddr);
      ackAt = 0; strbCycles = 0; strbAt = 0; otherAcks = 0;
      rdata = 'x; seenWaddr = 'x; seenWdata = 'x; issueRaddr = 'x;
      @(negedge clk);
      if (port == 0) begin
         req0 = 1; we0 = we; addr0 = addr; wdata0 = wdata; wstrb0 = wstrb;
      end else begin
         req1 = 1; we1 = we; addr1 = addr; wdata1 = wdata; wstrb1 = wstrb;
      end
      for (int n = 1; n <= 20 && ackAt == 0; n++) begin
         @(negedge clk);
         if (n == 1) issueRaddr = memRdAddr;
         if (memWstrb != 4'h0) begin
            strbCycles++; strbAt = n; seenWaddr = memWrAddr; seenWdata = memWrData;
         end
         if ((port == 0 ? ack1 : ack0) == 1'b1) otherAcks++;
         if ((port == 0 ? ack0 : ack1) == 1'b1) begin
            ackAt = n;
            rdata = (port == 0) ? rdata0 : rdata1;
         end
         if (n == dropAt || ackAt != 0) begin
            if (port == 0) req0 = 0; else req1 = 0;
         end
      end
   endtask

   int          ackAt, strbCyc, strbAt, other;
   logic [31:0] rd, wa, wd, ra;
   int          order [6];
   int          nAcks, doubles, both, prevAck, stray;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0100_0000 + 32'(i);
      mem[4] = 32'hDEADBEEF;
      mem[8] = 32'h11223344;

      repeat (3) @(negedge clk);
      check("rst_ack0", 32'(ack0), 32'h0);
      check("rst_ack1", 32'(ack1), 32'h0);
      check("rst_wstrb", 32'(memWstrb), 32'h0);
      check("rst_raddr", memRdAddr, 32'h0);
      check("rst_rdata0", rdata0, 32'h0);
      rst = 0;

      // Port 0 read of 0x10
      runTxn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, ackAt, strbCyc, strbAt, other, rd, wa, wd, ra);
      check("rd_ack_time", 32'(ackAt), 32'd3);
      check("rd_data", rd, 32'hDEADBEEF);
      check("rd_other_ack", 32'(other), 32'd0);
      check("rd_wstrb_cycles", 32'(strbCyc), 32'd0);
      check("rd_issue_addr", ra, 32'h10);

      // Port 1 byte write of 0xA5 to 0x20
      runTxn(1, 1'b1, 32'h20, 32'h0000_00A5, 4'b0001, 0, ackAt, strbCyc, strbAt, other, rd, wa, wd, ra);
      check("wr_ack_time", 32'(ackAt), 32'd3);
      check("wr_wstrb_cycles", 32'(strbCyc), 32'd1);
      check("wr_wstrb_at_issue", 32'(strbAt), 32'd1);
      check("wr_addr", wa, 32'h20);
      check("wr_data", wd, 32'h0000_00A5);
      check("wr_other_ack", 32'(other), 32'd0);

      runTxn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, ackAt, strbCyc, strbAt, other, rd, wa, wd, ra);
      check("rbw_ack_time", 32'(ackAt), 32'd3);
      check("rbw_byte0", 32'(rd[7:0]), 32'hA5);
      check("rbw_word", rd, 32'h112233A5);

      // Continuous contention from reset
      @(negedge clk);
      rst = 1;
      req0 = 1; we0 = 0; addr0 = 32'h10;
      req1 = 1; we1 = 0; addr1 = 32'h20;
      @(negedge clk);
      rst = 0;
      nAcks = 0; doubles = 0; both = 0; prevAck = 0;
      for (int i = 0; i < 6; i++) order[i] = -1;
      for (int c = 0; c < 60 && nAcks < 6; c++) begin
         @(negedge clk);
         if (ack0 && ack1) both++;
         if (ack0 || ack1) begin
            if (prevAck != 0) doubles++;
            order[nAcks] = ack1 ? 1 : 0;
            nAcks++;
         end
         prevAck = (ack0 || ack1) ? 1 : 0;
      end
      req0 = 0; req1 = 0;
      check("rr_ack_count", 32'(nAcks), 32'd6);
      for (int i = 0; i < 6; i++) check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
      check("rr_multi_cycle_ack", 32'(doubles), 32'd0);
      check("rr_both_acks", 32'(both), 32'd0);

      // Port 0 drops req during WAIT
      runTxn(0, 1'b0, 32'h10, 32'h0, 4'h0, 2, ackAt, strbCyc, strbAt, other, rd, wa, wd, ra);
      check("drop_ack_time", 32'(ackAt), 32'd3);
      check("drop_rdata", rd, 32'hDEADBEEF);
      @(negedge clk);
      check("drop_idle", 32'(dut.state), 32'(stIdle));
      check("drop_no_ack", 32'(ack0 | ack1), 32'h0);

      // Reset during WAIT of a port 1 read
      req1 = 1; we1 = 0; addr1 = 32'h10;
      @(negedge clk);
      @(negedge clk);
      check("abort_in_wait", 32'(dut.state), 32'(stWait));
      rst = 1; req1 = 0;
      @(negedge clk);
      check("abort_state", 32'(dut.state), 32'(stIdle));
      check("abort_acks", {30'h0, ack1, ack0}, 32'h0);
      check("abort_wstrb", 32'(memWstrb), 32'h0);
      check("abort_raddr", memRdAddr, 32'h0);
      check("abort_waddr", memWrAddr, 32'h0);
      check("abort_wdata", memWrData, 32'h0);
      check("abort_rdata0", rdata0, 32'h0);
      check("abort_rdata1", rdata1, 32'h0);
      rst = 0;
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack0 || ack1) stray++;
      end
      check("abort_no_ack", 32'(stray), 32'd0);
      req0 = 1; addr0 = 32'h10; req1 = 1; addr1 = 32'h10;
      ackAt = 0; other = 0;
      for (int n = 1; n <= 20 && ackAt == 0; n++) begin
         @(negedge clk);
         if (ack1) other++;
         if (ack0) ackAt = n;
      end
      req0 = 0; req1 = 0;
      check("post_rst_tie_time", 32'(ackAt), 32'd3);
      check("post_rst_tie_port1", 32'(other), 32'd0);

      // Latency-3 instance: read data tagged with the cycle it was presented
      @(negedge clk);
      req3 = 1; addr3 = 32'h40; memData3 = 32'h3000_0000;
      ackAt = 0; rd = 'x; other = 0;
      for (int n = 1; n <= 20 && ackAt == 0; n++) begin
         @(negedge clk);
         if (n == 1) ra = rd3Addr;
         if (ack3b) other++;
         if (ack3a) begin
            ackAt = n; rd = rdata3a; req3 = 0;
         end
         memData3 = 32'h3000_0000 + 32'(n);
      end
      req3 = 0;
      check("lat3_ack_time", 32'(ackAt), 32'd5);
      check("lat3_rdata", rd, 32'h3000_0004);
      check("lat3_issue_addr", ra, 32'h40);
      check("lat3_other_ack", 32'(other), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter sharing the single `simple_memory` instance between two bus masters: port 0 is the `ice_risc_rv` core and port 1 is a loader/debug master. It sits between the masters and the memory's split read/write address interface. It serialises one transaction at a time, with a fixed latency per transaction. Each requester gets a req/ack handshake, so neither master needs to know the other exists.

## Interface
Parameters:
- `pReadLatency`, default 1: cycles from memory address presentation to valid `iwMemReadData`. Legal range is 1–15.

Ports:
- `iwClk` in 1: system clock; the single clock domain.
- `iwRst` in 1: reset, synchronous, active-high.
- `iwReq0` / `iwReq1` in 1: transaction request. Held high with fields stable until ack.
- `iwWe0` / `iwWe1` in 1: 1 = write, 0 = read.
- `iwAddr0` / `iwAddr1` in 32: byte address.
- `iwWdata0` / `iwWdata1` in 32: write data.
- `iwWstrb0` / `iwWstrb1` in 4: byte enables for writes. Ignored for reads.
- `owAck0` / `owAck1` out 1: one-cycle completion pulse.
- `owRdata0` / `owRdata1` out 32: read data. Valid in the ack cycle.
- `owMemReadAddr` out 32: to the memory read address.
- `owMemWriteAddr` out 32: to the memory write address.
- `owMemWriteData` out 32: to the memory write data.
- `owMemWstrb` out 4: to the memory byte strobes. 0 means no write.
- `iwMemReadData` in 32: from memory.

## Operation
- FSM states are IDLE, ISSUE, WAIT and ACK.
- **IDLE**
  - With no request pending, stay in IDLE.
  - With one request pending, grant it.
  - With both requests pending, grant the port not granted last.
  - On grant, latch the winner's we/addr/wdata/wstrb and port index, then go to ISSUE.
- **ISSUE** (1 cycle)
  - Both memory address outputs are driven with the latched address, and `owMemWriteData` with the latched wdata.
  - `owMemWstrb` = latched wstrb if we=1, else 0.
  - Load the wait counter with `pReadLatency`-1 and go to WAIT.
- **WAIT** (`pReadLatency` cycles)
  - `owMemWstrb` = 0.
  - The counter decrements each cycle. In the cycle the counter is 0, capture `iwMemReadData` into the granted port's rdata register and go to ACK.
- **ACK** (1 cycle)
  - The granted port's ack = 1; the other ack = 0.
  - Update the last-grant pointer and go to IDLE.
  - Requests are not sampled in this cycle.
- Memory address outputs hold the last latched address outside ISSUE. `owMemWstrb` is nonzero only in ISSUE.
- `owRdataN` holds its last captured value until that port's next completion.
  - For write transactions the captured value is whatever memory returns; masters must ignore it.
- A requester that drops req mid-transaction does not abort it; the transaction completes and ack still pulses.
- A requester may re-assert req in the cycle after ack. It then competes in IDLE with round-robin fairness applied.
- **Reset** (synchronous, any state)
  - Next state is IDLE.
  - Both acks, `owMemWstrb`, both address outputs, `owMemWriteData` and both rdata registers are 0.
  - The last-grant pointer is set to port 1, so port 0 wins the first tie.
  - A transaction in flight at reset is dropped with no ack. A write whose ISSUE cycle already completed stays written.

## Timing
- Req seen high in IDLE at cycle T. Then ISSUE is T+1, WAIT is T+2 … T+1+`pReadLatency`, and ACK is T+2+`pReadLatency`.
- With `pReadLatency`=1, ack arrives 3 cycles after req is first seen; back-to-back throughput is one transaction per 4 cycles.
- A losing requester waits at most one full transaction of the other port. Under continuous contention, grants alternate 0,1,0,1.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `ice_risc_pkg` holds:
  - the state encoding typedef;
  - port index constants `cPortCore`=0 and `cPortLoader`=1;
  - the bus width constants: 32 data, 4 strobe.
- One natural sub-module, `mem_arbiter_rr`: a two-way round-robin picker.
  - Inputs: the two reqs and the last-grant pointer.
  - Outputs: grant valid and grant index.
  - Purely combinational.
- The FSM, the wait counter, the latched request and the rdata registers stay in `mem_arbiter`.

## Test plan
- Reset, then port 0 reads address 0x10 holding 0xDEADBEEF, with `pReadLatency`=1:
  - `owAck0` is high exactly at T+3 with `owRdata0`=0xDEADBEEF;
  - `owAck1` stays 0;
  - `owMemWstrb` stays 0 throughout.
- Port 1 writes 0x000000A5 with wstrb 4'b0001 to address 0x20:
  - `owMemWstrb`=0001 for exactly one cycle (ISSUE), with `owMemWriteAddr`=0x20;
  - `owAck1` pulses at T+3;
  - a subsequent port 0 read of 0x20 returns byte 0 = 0xA5.
- Both reqs held continuously from reset for 6 transactions: grant order is 0,1,0,1,0,1, and each ack is a single-cycle pulse.
- `pReadLatency`=3, port 0 read: ack arrives at T+5, and rdata equals the memory data presented 3 cycles after ISSUE.
- Assert `iwRst` during WAIT of a port 1 read:
  - the next cycle is IDLE with all outputs 0;
  - no ack is ever pulsed for the aborted transaction;
  - after reset release, a tie goes to port 0.
- Port 0 drops req during WAIT: `owAck0` still pulses at T+3 and the arbiter returns to IDLE normally.
